// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM preconditioner slice.
package pwm_pkg;

    localparam int PWM_WIDTH = 13;
    localparam int PWM_DEPTH = 249;
    localparam int PIPE_LAT  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } pre_state_t;

    typedef logic [PWM_WIDTH-1:0] pwm_t;

    // Width of an index able to address every transducer (at least one bit).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pwm_edge_calc.sv
// Three-stage pipeline turning (cycle, duty, phase) into PWM rise/fall times.
// Arithmetic runs one bit wider than the operands so sums never overflow.
module pwm_edge_calc
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [WIDTH-1:0] in_cycle,
    input  logic [WIDTH-1:0] in_duty,
    input  logic [WIDTH-1:0] in_phase,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [WIDTH-1:0] out_rise,
    output logic [WIDTH-1:0] out_fall
);

    localparam int XW = WIDTH + 1;
    localparam logic [XW-1:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};

    // stage 1 combinational results
    logic [XW-1:0] cyc_x_s, duty_x_s, phase_x_s;
    logic [XW-1:0] p_s, d_s, lo_s, inc_s, hi_s;
    // stage 1 registers
    logic             v1_r;
    logic [IDX_W-1:0] idx1_r;
    logic [XW-1:0]    cyc1_r, p1_r, d1_r, lo1_r, hi1_r;
    // stage 2 combinational results
    logic [XW-1:0] r_s, fsum_s, f_s;
    // stage 2 registers
    logic             v2_r;
    logic [IDX_W-1:0] idx2_r;
    logic [XW-1:0]    cyc2_r, d2_r, r2_r, f2_r;
    // stage 3 combinational results
    logic [XW-1:0] rise_s, fall_s;
    // stage 3 registers
    logic             v3_r;
    logic [IDX_W-1:0] idx3_r;
    logic [WIDTH-1:0] rise3_r, fall3_r;

    // Bits that are provably zero or only needed for the halving step.
    logic unused_bits_s;
    assign unused_bits_s = ^{inc_s[0], rise_s[WIDTH], fall_s[WIDTH]};

    // Stage 1: fold phase into one period, clamp duty, split it around the phase.
    always_comb begin
        cyc_x_s   = {1'b0, in_cycle};
        duty_x_s  = {1'b0, in_duty};
        phase_x_s = {1'b0, in_phase};
        p_s       = (phase_x_s >= cyc_x_s) ? (phase_x_s - cyc_x_s) : phase_x_s;
        d_s       = (duty_x_s < cyc_x_s) ? duty_x_s : cyc_x_s;
        lo_s      = {1'b0, d_s[XW-1:1]};
        inc_s     = d_s + ONE_X;
        hi_s      = {1'b0, inc_s[XW-1:1]};
    end

    // Stage 1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r   <= 1'b0;
            idx1_r <= '0;
            cyc1_r <= '0;
            p1_r   <= '0;
            d1_r   <= '0;
            lo1_r  <= '0;
            hi1_r  <= '0;
        end else begin
            v1_r   <= in_valid;
            idx1_r <= in_idx;
            cyc1_r <= cyc_x_s;
            p1_r   <= p_s;
            d1_r   <= d_s;
            lo1_r  <= lo_s;
            hi1_r  <= hi_s;
        end
    end

    // Stage 2: place rising edge before and falling edge after the phase, modulo cycle.
    always_comb begin
        r_s    = (p1_r >= lo1_r) ? (p1_r - lo1_r) : (p1_r + cyc1_r - lo1_r);
        fsum_s = p1_r + hi1_r;
        f_s    = (fsum_s >= cyc1_r) ? (fsum_s - cyc1_r) : fsum_s;
    end

    // Stage 2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r   <= 1'b0;
            idx2_r <= '0;
            cyc2_r <= '0;
            d2_r   <= '0;
            r2_r   <= '0;
            f2_r   <= '0;
        end else begin
            v2_r   <= v1_r;
            idx2_r <= idx1_r;
            cyc2_r <= cyc1_r;
            d2_r   <= d1_r;
            r2_r   <= r_s;
            f2_r   <= f_s;
        end
    end

    // Stage 3: zero duty (including zero cycle) never goes high, full duty never goes low.
    always_comb begin
        rise_s = '0;
        fall_s = '0;
        if (d2_r == '0) begin
            rise_s = '0;
            fall_s = '0;
        end else if (d2_r == cyc2_r) begin
            rise_s = '0;
            fall_s = cyc2_r;
        end else begin
            rise_s = r2_r;
            fall_s = f2_r;
        end
    end

    // Stage 3 register feeding the write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_r    <= 1'b0;
            idx3_r  <= '0;
            rise3_r <= '0;
            fall3_r <= '0;
        end else begin
            v3_r    <= v2_r;
            idx3_r  <= idx2_r;
            rise3_r <= rise_s[WIDTH-1:0];
            fall3_r <= fall_s[WIDTH-1:0];
        end
    end

    assign out_valid = v3_r;
    assign out_idx   = idx3_r;
    assign out_rise  = rise3_r;
    assign out_fall  = fall3_r;

endmodule

// File: rtl/pwm_preconditioner.sv
// Sweeps all transducers through the edge pipeline once per silencer update
// and holds the resulting rise/fall table until the next complete pass.
module pwm_preconditioner
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH,
    parameter int DEPTH = PWM_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             update,
    input  logic [WIDTH-1:0] cycle [DEPTH],
    input  logic [WIDTH-1:0] duty  [DEPTH],
    input  logic [WIDTH-1:0] phase [DEPTH],
    output logic [WIDTH-1:0] rise  [DEPTH],
    output logic [WIDTH-1:0] fall  [DEPTH],
    output logic             done
);

    localparam int IDX_W = idx_width(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [1:0]       FLUSH_LAST = 2'(PIPE_LAT - 1);

    pre_state_t       state_r, state_nxt_s;
    logic             update_q_r;
    logic             start_s;
    logic [IDX_W-1:0] idx_r, idx_nxt_s;
    logic [1:0]       flush_cnt_r, flush_nxt_s;
    logic             pending_r, pending_nxt_s;
    logic             done_r, done_nxt_s;
    logic             issue_s;

    logic             res_valid_s;
    logic [IDX_W-1:0] res_idx_s;
    logic [WIDTH-1:0] res_rise_s, res_fall_s;

    logic [WIDTH-1:0] rise_r [DEPTH];
    logic [WIDTH-1:0] fall_r [DEPTH];

    assign start_s = update & ~update_q_r;

    // Next-state logic: IDLE waits for a start (or a queued one), RUN issues
    // every index once, FLUSH drains the pipeline before signalling done.
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        flush_nxt_s   = flush_cnt_r;
        pending_nxt_s = pending_r;
        done_nxt_s    = done_r;
        issue_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_s || pending_r) begin
                    state_nxt_s   = RUN;
                    idx_nxt_s     = '0;
                    pending_nxt_s = 1'b0;
                    done_nxt_s    = 1'b0;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            RUN: begin
                issue_s       = 1'b1;
                pending_nxt_s = pending_r | start_s;
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = FLUSH;
                    idx_nxt_s   = '0;
                    flush_nxt_s = 2'd0;
                end else begin
                    idx_nxt_s   = idx_r + IDX_ONE;
                end
            end
            FLUSH: begin
                if (flush_cnt_r == FLUSH_LAST) begin
                    flush_nxt_s = 2'd0;
                    if (pending_r || start_s) begin
                        // A newer update arrived mid-pass: rerun without exposing done.
                        state_nxt_s   = RUN;
                        idx_nxt_s     = '0;
                        pending_nxt_s = 1'b0;
                        done_nxt_s    = 1'b0;
                    end else begin
                        state_nxt_s   = IDLE;
                        pending_nxt_s = 1'b0;
                        done_nxt_s    = 1'b1;
                    end
                end else begin
                    flush_nxt_s   = flush_cnt_r + 2'd1;
                    pending_nxt_s = pending_r | start_s;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                idx_nxt_s     = '0;
                flush_nxt_s   = 2'd0;
                pending_nxt_s = 1'b0;
                done_nxt_s    = 1'b0;
            end
        endcase
    end

    // Control registers: update edge detector, FSM state, index, flush count, pending, done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            update_q_r  <= 1'b0;
            state_r     <= IDLE;
            idx_r       <= '0;
            flush_cnt_r <= 2'd0;
            pending_r   <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            update_q_r  <= update;
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            flush_cnt_r <= flush_nxt_s;
            pending_r   <= pending_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    pwm_edge_calc #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_edge_calc (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (issue_s),
        .in_idx    (idx_r),
        .in_cycle  (cycle[idx_r]),
        .in_duty   (duty[idx_r]),
        .in_phase  (phase[idx_r]),
        .out_valid (res_valid_s),
        .out_idx   (res_idx_s),
        .out_rise  (res_rise_s),
        .out_fall  (res_fall_s)
    );

    // Write-back: each retiring index updates only its own table entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rise_r[i] <= '0;
                fall_r[i] <= '0;
            end
        end else begin
            if (res_valid_s) begin
                rise_r[res_idx_s] <= res_rise_s;
                fall_r[res_idx_s] <= res_fall_s;
            end else begin
                rise_r[res_idx_s] <= rise_r[res_idx_s];
                fall_r[res_idx_s] <= fall_r[res_idx_s];
            end
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;
    assign done = done_r;

endmodule

// File: tb/tb_pwm_preconditioner.sv
// Scoreboard bench: stimulus pushes expected tables and completion cycles,
// a monitor pops and compares them whenever done rises.
module tb_pwm_preconditioner;
    import pwm_pkg::*;

    localparam int DEPTH = PWM_DEPTH;
    localparam int NVEC  = 13;
    localparam int LAT   = DEPTH + 4;

    typedef struct packed {
        int   idx;
        pwm_t r;
        pwm_t f;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    logic update;
    pwm_t cyc_in   [DEPTH];
    pwm_t duty_in  [DEPTH];
    pwm_t phase_in [DEPTH];
    pwm_t rise_o   [DEPTH];
    pwm_t fall_o   [DEPTH];
    logic done;

    // Hand-computed vectors: cycle, duty, phase -> rise, fall
    int vec_c [NVEC] = '{4096, 4096, 4096, 4096, 4096,  0, 4096, 4096, 4096, 100, 8191, 1000, 4096};
    int vec_d [NVEC] = '{2048,  100,    0, 5000,   10, 50, 4096,    1, 4095,   3, 8190,  999, 2048};
    int vec_p [NVEC] = '{1024,    0,  123,    7, 4100, 30,  500,    0,    0,  99, 8190,    0, 4095};
    int vec_r [NVEC] = '{   0, 4046,    0,    0, 4095,  0,    0,    0, 2049,  98, 4095,  501, 3071};
    int vec_f [NVEC] = '{2048,   50,    0, 4096,    9,  0, 4096,    1, 2048,   1, 4094,  500, 1023};

    int   pass_q [$];
    ent_t ent_q  [$];
    int   total = 0;
    int   bad = 0;
    int   cyc_cnt = 0;
    int   passes_seen = 0;
    logic prev_done = 1'b0;

    pwm_preconditioner #(
        .WIDTH (PWM_WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .update (update),
        .cycle  (cyc_in),
        .duty   (duty_in),
        .phase  (phase_in),
        .rise   (rise_o),
        .fall   (fall_o),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check_val(input string nm, input int idx, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s idx=%0d got=%0d expected=%0d", nm, idx, got, exp);
        end
    endtask

    task automatic set_inputs(input int off);
        for (int i = 0; i < DEPTH; i++) begin
            int v;
            v = (i + off) % NVEC;
            cyc_in[i]   = pwm_t'(vec_c[v]);
            duty_in[i]  = pwm_t'(vec_d[v]);
            phase_in[i] = pwm_t'(vec_p[v]);
        end
    endtask

    task automatic push_expect(input int off, input int lat);
        pass_q.push_back(cyc_cnt + lat);
        for (int i = 0; i < DEPTH; i++) begin
            int v;
            v = (i + off) % NVEC;
            ent_q.push_back('{idx: i, r: pwm_t'(vec_r[v]), f: pwm_t'(vec_f[v])});
        end
    endtask

    // Called at a negedge: raise update for one clock.
    task automatic pulse_update();
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic wait_passes(input int target, input int budget);
        int n;
        n = 0;
        while (passes_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("pass_count", target, passes_seen, target);
    endtask

    task automatic check_reset_state();
        check_val("reset_done", 0, int'(done), 0);
        for (int i = 0; i < DEPTH; i++) begin
            check_val("reset_rise", i, int'(rise_o[i]), 0);
            check_val("reset_fall", i, int'(fall_o[i]), 0);
        end
    endtask

    // Monitor: every rising done retires one expected pass.
    always @(negedge clk) begin
        if (done && !prev_done) begin
            passes_seen++;
            if (pass_q.size() == 0) begin
                check_val("unexpected_done", passes_seen, 1, 0);
            end else begin
                int exp_c;
                exp_c = pass_q.pop_front();
                check_val("done_latency", passes_seen, cyc_cnt, exp_c);
                for (int j = 0; j < DEPTH; j++) begin
                    if (ent_q.size() == 0) begin
                        check_val("missing_entry", j, 0, 1);
                    end else begin
                        ent_t e;
                        e = ent_q.pop_front();
                        check_val("rise", e.idx, int'(rise_o[e.idx]), int'(e.r));
                        check_val("fall", e.idx, int'(fall_o[e.idx]), int'(e.f));
                    end
                end
            end
        end
        prev_done = done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        update = 1'b0;
        set_inputs(0);
        repeat (3) @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;
        @(negedge clk);

        // Single pass over all directed vectors, latency DEPTH+4
        push_expect(0, LAT);
        pulse_update();
        wait_passes(1, LAT + 20);
        repeat (5) @(negedge clk);
        check_val("done_hold", 0, int'(done), 1);

        // Extra updates mid-pass collapse into exactly one follow-up pass
        set_inputs(3);
        push_expect(3, 2 * LAT - 1);
        pulse_update();
        check_val("done_drop", 0, int'(done), 0);
        repeat (48) @(negedge clk);
        pulse_update();
        repeat (20) @(negedge clk);
        pulse_update();
        wait_passes(2, 3 * LAT);
        repeat (LAT + 20) @(negedge clk);
        check_val("no_extra_pass", 0, passes_seen, 2);
        check_val("done_idle", 0, int'(done), 1);

        // Async reset mid-pass with a queued update: everything clears, nothing resumes
        set_inputs(7);
        pulse_update();
        repeat (60) @(negedge clk);
        pulse_update();
        repeat (59) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 20) @(negedge clk);
        check_val("no_resume_done", 0, int'(done), 0);
        check_val("no_resume_pass", 0, passes_seen, 2);

        // Fresh pass after reset
        push_expect(7, LAT);
        pulse_update();
        wait_passes(3, LAT + 20);

        check_val("pass_q_empty", 0, pass_q.size(), 0);
        check_val("ent_q_empty", 0, ent_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
